pipe_tx_gearbox: RTL and testbench
==================================

PIPE_TX_GEARBOX -- requirements
Module: pipe_tx_gearbox

Interface
REQ-001 SHALL have parameter PIPE_DATA_WIDTH, default 256, width of the DLL-side PIPE word.
REQ-002 SHALL have parameter PHY_DATA_WIDTH, default 64, width of one PHY-side beat; PIPE_DATA_WIDTH/PHY_DATA_WIDTH (RATIO) SHALL be a power of two ≥2.
REQ-003 SHALL have parameter DEPTH_LG2, default 3, log2 of the FIFO depth in PIPE words.
REQ-004 clk  input  1  single clock; all logic on its rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 pipe_txdata_i  input  PIPE_DATA_WIDTH  TX word from the DLL.
REQ-007 pipe_txvalid_i  input  1  word valid; no backpressure exists toward the DLL.
REQ-008 phy_data_o  output  PHY_DATA_WIDTH  current beat to the PHY.
REQ-009 phy_valid_o  output  1  beat valid.
REQ-010 phy_ready_i  input  1  PHY accepts the beat when phy_valid_o && phy_ready_i.
REQ-011 level_o  output  DEPTH_LG2+1  PIPE words currently held in the FIFO, excluding the word being serialized.
REQ-012 overflow_o  output  1  sticky flag: at least one word was dropped.

Function
REQ-013 Write: on cycle with pipe_txvalid_i=1 and FIFO not full, the word SHALL be pushed; if full (from registered count), the word SHALL be dropped and overflow_o set to 1 at the next edge, even if a pop occurs in the same cycle.
REQ-014 Serializer FSM SHALL have states IDLE and SEND; beat counter SHALL be log2(RATIO) bits.
REQ-015 IDLE: when FIFO non-empty, pop head into the shift register, clear beat counter, go to SEND at the next edge.
REQ-016 SEND: phy_valid_o=1; phy_data_o = bits [(cnt+1)*PHY_DATA_WIDTH-1 : cnt*PHY_DATA_WIDTH] of the held word (LSB beat first).
REQ-017 SEND: on handshake with cnt<RATIO-1, increment cnt; without handshake, phy_data_o and phy_valid_o SHALL hold unchanged.
REQ-018 SEND: on handshake with cnt=RATIO-1 and FIFO non-empty, pop next word, cnt=0, stay in SEND (no bubble); if FIFO empty, go to IDLE, phy_valid_o=0 next cycle.
REQ-019 Latency: word pushed at edge N into an empty FIFO with FSM in IDLE SHALL produce phy_valid_o=1 with beat 0 in cycle N+2 (i.e., after edge N+1).
REQ-020 Simultaneous push and pop SHALL leave level_o unchanged; FIFO pointers SHALL wrap modulo 2^DEPTH_LG2.
REQ-021 phy_valid_o SHALL never deassert without a completed handshake once asserted in SEND.

Reset
REQ-022 On rst=1 at an edge: FSM=IDLE, cnt=0, pointers=0, level_o=0, phy_valid_o=0, phy_data_o=0, overflow_o=0.
REQ-023 Reset mid-word SHALL discard the partially sent word and all FIFO contents; no beats after reset until a new push.

Configuration
REQ-024 Macro PIPE_TX_GEARBOX_STATS_EN: when defined, module SHALL add outputs words_sent_o (32) counting words whose last beat handshook, and drops_o (16) counting dropped words, both saturating, both reset to 0.
REQ-025 Without PIPE_TX_GEARBOX_STATS_EN those ports and counters SHALL not exist; all other behaviour identical.

Structure
REQ-026 Widths defaults and the FSM state enum (IDLE, SEND) SHALL live in shared package pcie_pipe_pkg.
REQ-027 FIFO storage SHALL be a sub-module pipe_tx_fifo (push/pop/full/empty/count); FSM and serializer in the top.

Verification
REQ-028 Single word 0x…_0004_0003_0002_0001 (64-bit lanes 1,2,3,4), ready=1 -> beats 1,2,3,4 in cycles N+2..N+5, then phy_valid_o=0.
REQ-029 Three back-to-back words, ready=1 -> 12 consecutive beats, no idle cycle, level_o peaks at 2.
REQ-030 ready toggling 1,0,1,0 during a word -> each beat held stable while ready=0, no beat lost or duplicated.
REQ-031 ready=0, push 9 words with DEPTH_LG2=3 -> 8 stored plus one in serializer? No: first word popped into serializer, 8 stored, 0 dropped; tenth push -> overflow_o=1, drops_o=1 (STATS_EN).
REQ-032 rst asserted after beat 2 of a word with 3 words queued -> next cycle phy_valid_o=0, level_o=0, overflow_o=0; new push yields beat 0 at N+2.

Source files
------------

// File: rtl/pcie_pipe_pkg.sv
// Shared PIPE TX gearbox definitions: default widths and serializer FSM states.
package pcie_pipe_pkg;

    localparam int PIPE_DATA_WIDTH_DEF = 256;
    localparam int PHY_DATA_WIDTH_DEF  = 64;
    localparam int DEPTH_LG2_DEF       = 3;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } tx_state_e;

endpackage

// File: rtl/pipe_tx_fifo.sv
// Word FIFO in front of the serializer. Push/pop are qualified internally
// against full/empty, so callers may request freely.
module pipe_tx_fifo #(
    parameter int W         = 256,
    parameter int DEPTH_LG2 = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push_i,
    input  logic [W-1:0]         din_i,
    input  logic                 pop_i,
    output logic [W-1:0]         dout_o,
    output logic                 full_o,
    output logic                 empty_o,
    output logic [DEPTH_LG2:0]   count_o
);
    localparam int DEPTH = 1 << DEPTH_LG2;

    logic [W-1:0]         mem_q [DEPTH];
    logic [DEPTH_LG2-1:0] wptr_q, wptr_d;
    logic [DEPTH_LG2-1:0] rptr_q, rptr_d;
    logic [DEPTH_LG2:0]   count_q, count_d;
    logic                 do_push, do_pop;

    assign full_o  = (count_q == (DEPTH_LG2+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign dout_o  = mem_q[rptr_q];

    // A push that arrives while full is dropped even if a pop frees a slot this cycle.
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Pointer and occupancy next-state; pointers wrap naturally at DEPTH.
    always_comb begin
        wptr_d  = wptr_q + DEPTH_LG2'(do_push);
        rptr_d  = rptr_q + DEPTH_LG2'(do_pop);
        count_d = count_q + (DEPTH_LG2+1)'(do_push) - (DEPTH_LG2+1)'(do_pop);
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= din_i;
    end

endmodule

// File: rtl/pipe_tx_gearbox.sv
// PIPE TX gearbox: buffers wide DLL words and serializes them LSB beat first
// onto a narrower PHY interface with valid/ready handshake.
// Optional: PIPE_TX_GEARBOX_STATS_EN adds saturating words_sent_o / drops_o counters.
module pipe_tx_gearbox
    import pcie_pipe_pkg::*;
#(
    parameter int PIPE_DATA_WIDTH = PIPE_DATA_WIDTH_DEF,
    parameter int PHY_DATA_WIDTH  = PHY_DATA_WIDTH_DEF,
    parameter int DEPTH_LG2       = DEPTH_LG2_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [PIPE_DATA_WIDTH-1:0] pipe_txdata_i,
    input  logic                       pipe_txvalid_i,
    output logic [PHY_DATA_WIDTH-1:0]  phy_data_o,
    output logic                       phy_valid_o,
    input  logic                       phy_ready_i,
    output logic [DEPTH_LG2:0]         level_o,
    output logic                       overflow_o
`ifdef PIPE_TX_GEARBOX_STATS_EN
    ,
    output logic [31:0]                words_sent_o,
    output logic [15:0]                drops_o
`endif
);
    localparam int RATIO = PIPE_DATA_WIDTH / PHY_DATA_WIDTH;
    localparam int CNT_W = $clog2(RATIO);

    tx_state_e                  state_q, state_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic [PIPE_DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic                       overflow_q;
    logic                       pop;
    logic                       hs, last;
    logic                       fifo_full, fifo_empty;
    logic [PIPE_DATA_WIDTH-1:0] fifo_dout;

    pipe_tx_fifo #(
        .W         (PIPE_DATA_WIDTH),
        .DEPTH_LG2 (DEPTH_LG2)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (pipe_txvalid_i),
        .din_i   (pipe_txdata_i),
        .pop_i   (pop),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (level_o)
    );

    assign hs   = (state_q == SEND) && phy_ready_i;
    assign last = (cnt_q == CNT_W'(RATIO-1));

    // Serializer state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shreg_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
        end
    end

    // Next-state: load a word from the FIFO when idle or right after the last
    // beat handshakes, so back-to-back words go out without a bubble.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shreg_d = fifo_dout;
                    cnt_d   = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (hs) begin
                    if (!last) begin
                        cnt_d = cnt_q + 1'b1;
                    end else if (!fifo_empty) begin
                        pop     = 1'b1;
                        shreg_d = fifo_dout;
                        cnt_d   = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs come straight from registers, so they hold while ready is low.
    always_comb begin
        phy_valid_o = (state_q == SEND);
        phy_data_o  = shreg_q[cnt_q*PHY_DATA_WIDTH +: PHY_DATA_WIDTH];
        overflow_o  = overflow_q;
    end

    // Sticky overflow: set whenever a word is presented to a full FIFO.
    always_ff @(posedge clk) begin
        if (rst)                              overflow_q <= 1'b0;
        else if (pipe_txvalid_i && fifo_full) overflow_q <= 1'b1;
    end

`ifdef PIPE_TX_GEARBOX_STATS_EN
    logic [31:0] words_sent_q;
    logic [15:0] drops_q;

    // Saturating counters of completed words and dropped words.
    always_ff @(posedge clk) begin
        if (rst) begin
            words_sent_q <= '0;
            drops_q      <= '0;
        end else begin
            if (hs && last && (words_sent_q != '1))             words_sent_q <= words_sent_q + 1'b1;
            if (pipe_txvalid_i && fifo_full && (drops_q != '1)) drops_q      <= drops_q + 1'b1;
        end
    end

    assign words_sent_o = words_sent_q;
    assign drops_o      = drops_q;
`endif

endmodule

// File: tb/tb_pipe_tx_gearbox.sv
// Scoreboard bench for pipe_tx_gearbox at default parameters (256 -> 4 x 64).
// Word k carries lane j value k*16+j+1.
module tb_pipe_tx_gearbox;
    logic         clk = 1'b0;
    logic         rst;
    logic [255:0] pipe_txdata_i;
    logic         pipe_txvalid_i;
    logic [63:0]  phy_data_o;
    logic         phy_valid_o;
    logic         phy_ready_i;
    logic [3:0]   level_o;
    logic         overflow_o;
`ifdef PIPE_TX_GEARBOX_STATS_EN
    logic [31:0]  words_sent_o;
    logic [15:0]  drops_o;
`endif

    pipe_tx_gearbox dut (
        .clk            (clk),
        .rst            (rst),
        .pipe_txdata_i  (pipe_txdata_i),
        .pipe_txvalid_i (pipe_txvalid_i),
        .phy_data_o     (phy_data_o),
        .phy_valid_o    (phy_valid_o),
        .phy_ready_i    (phy_ready_i),
        .level_o        (level_o),
        .overflow_o     (overflow_o)
`ifdef PIPE_TX_GEARBOX_STATS_EN
        ,
        .words_sent_o   (words_sent_o),
        .drops_o        (drops_o)
`endif
    );

    always #5 clk = ~clk;

    int          n_chk  = 0;
    int          n_fail = 0;
    logic [63:0] exp_q[$];

    function automatic void chk(string name, logic [255:0] act, logic [255:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic logic [255:0] mkword(int k);
        logic [255:0] w;
        for (int j = 0; j < 4; j++) w[j*64 +: 64] = 64'(k*16 + j + 1);
        return w;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present word k for one edge; queue its beats if it should be stored.
    task automatic push_word(int k, bit store);
        logic [255:0] w;
        w = mkword(k);
        pipe_txdata_i  = w;
        pipe_txvalid_i = 1'b1;
        if (store) for (int j = 0; j < 4; j++) exp_q.push_back(w[j*64 +: 64]);
        step();
        pipe_txvalid_i = 1'b0;
    endtask

    task automatic drain(string name);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !phy_valid_o) done = 1'b1;
        end
        chk(name, 256'(done), 256'(1));
    endtask

    // Monitor: pops expected beats on handshake, checks stability while stalled.
    logic        prev_v = 1'b0, prev_r = 1'b0;
    logic [63:0] prev_d = '0;
    always @(negedge clk) begin
        if (rst) begin
            prev_v = 1'b0;
        end else begin
            if (prev_v && !prev_r) begin
                chk("hold_valid", 256'(phy_valid_o), 256'(1));
                chk("hold_data", 256'(phy_data_o), 256'(prev_d));
            end
            if (phy_valid_o && phy_ready_i) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_beat: got %0h expected none", phy_data_o);
                end else begin
                    chk("beat", 256'(phy_data_o), 256'(exp_q.pop_front()));
                end
            end
            prev_v = phy_valid_o;
            prev_r = phy_ready_i;
            prev_d = phy_data_o;
        end
    end

    initial begin
        int vcnt, vfirst, vlast, lpeak, vseen;
        rst = 1'b1; pipe_txvalid_i = 1'b0; pipe_txdata_i = '0; phy_ready_i = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", 256'(phy_valid_o), 256'(0));
        chk("rst_data", 256'(phy_data_o), 256'(0));
        chk("rst_level", 256'(level_o), 256'(0));
        chk("rst_overflow", 256'(overflow_o), 256'(0));
        step();
        rst = 1'b0;
        phy_ready_i = 1'b1;

        // Single word: latency N+2, beats 1..4, then idle.
        push_word(0, 1);
        @(negedge clk);
        chk("lat_n1_valid", 256'(phy_valid_o), 256'(0));
        @(negedge clk);
        chk("lat_n2_valid", 256'(phy_valid_o), 256'(1));
        chk("lat_n2_beat0", 256'(phy_data_o), 256'(64'h1));
        repeat (4) @(negedge clk);
        chk("single_end_valid", 256'(phy_valid_o), 256'(0));
        chk("single_all_beats", 256'(exp_q.size()), 256'(0));

        // Three back-to-back words: 12 contiguous beats, level peaks at 2.
        vcnt = 0; vfirst = -1; vlast = -1; lpeak = 0;
        fork
            begin
                push_word(1, 1);
                push_word(2, 1);
                push_word(3, 1);
            end
            begin
                for (int i = 0; i < 24; i++) begin
                    @(negedge clk);
                    if (int'(level_o) > lpeak) lpeak = int'(level_o);
                    if (phy_valid_o) begin
                        vcnt++;
                        if (vfirst < 0) vfirst = i;
                        vlast = i;
                    end
                end
            end
        join
        chk("b2b_beats", 256'(vcnt), 256'(12));
        chk("b2b_no_bubble", 256'(vlast - vfirst + 1), 256'(12));
        chk("b2b_level_peak", 256'(lpeak), 256'(2));

        // Ready toggling during a word.
        phy_ready_i = 1'b0;
        push_word(4, 1);
        vseen = 0;
        for (int i = 0; i < 10 && vseen == 0; i++) begin
            @(negedge clk);
            if (phy_valid_o) vseen = 1;
        end
        chk("toggle_started", 256'(vseen), 256'(1));
        for (int i = 0; i < 7; i++) begin
            step();
            phy_ready_i = (i % 2 == 0);
        end
        step();
        phy_ready_i = 1'b1;
        drain("toggle_drained");

        // Fill with ready low: 9 accepted (1 in serializer + 8 stored), 10th dropped.
        step();
        phy_ready_i = 1'b0;
        for (int k = 5; k < 14; k++) push_word(k, 1);
        @(negedge clk);
        chk("full_level", 256'(level_o), 256'(8));
        chk("full_no_overflow", 256'(overflow_o), 256'(0));
        step();
        push_word(14, 0);
        @(negedge clk);
        chk("drop_overflow", 256'(overflow_o), 256'(1));
        chk("drop_level", 256'(level_o), 256'(8));
`ifdef PIPE_TX_GEARBOX_STATS_EN
        chk("drop_count", 256'(drops_o), 256'(1));
`endif
        step();
        phy_ready_i = 1'b1;
        drain("full_drained");
        chk("drained_level", 256'(level_o), 256'(0));
        chk("overflow_sticky", 256'(overflow_o), 256'(1));
`ifdef PIPE_TX_GEARBOX_STATS_EN
        chk("words_sent", 256'(words_sent_o), 256'(14));
`endif

        // Reset mid-word with 3 words queued behind the one being sent.
        step();
        phy_ready_i = 1'b0;
        for (int k = 20; k < 24; k++) push_word(k, 1);
        step();
        phy_ready_i = 1'b1;
        step();
        step();
        phy_ready_i = 1'b0;
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        chk("pre_rst_level", 256'(level_o), 256'(3));
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_valid", 256'(phy_valid_o), 256'(0));
        chk("mid_rst_level", 256'(level_o), 256'(0));
        chk("mid_rst_overflow", 256'(overflow_o), 256'(0));
`ifdef PIPE_TX_GEARBOX_STATS_EN
        chk("mid_rst_words", 256'(words_sent_o), 256'(0));
        chk("mid_rst_drops", 256'(drops_o), 256'(0));
`endif
        step();
        phy_ready_i = 1'b1;
        vseen = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (phy_valid_o) vseen++;
        end
        chk("post_rst_quiet", 256'(vseen), 256'(0));
        step();
        push_word(24, 1);
        @(negedge clk);
        chk("post_rst_lat_n1", 256'(phy_valid_o), 256'(0));
        @(negedge clk);
        chk("post_rst_lat_n2", 256'(phy_valid_o), 256'(1));
        chk("post_rst_beat0", 256'(phy_data_o), 256'(64'(24*16 + 1)));
        drain("post_rst_drained");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
